// File: rtl/abs_diff_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : abs_diff_chk_pkg
// Brief    : Shared FSM states, widths and the 2-bit |x-y| helper for the
//            abs-diff error-threshold checker.
// Revision : 1.0 - initial release
// ============================================================================
package abs_diff_chk_pkg;

    localparam int C_OP_W  = 2;
    localparam int C_VEC_W = 4;
    localparam int C_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [C_OP_W-1:0] abs_diff2(input logic [C_OP_W-1:0] x,
                                                    input logic [C_OP_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/abs_diff_exact.sv
`default_nettype none
// ============================================================================
// Module   : abs_diff_exact
// Brief    : Golden |a-b| for a 4-bit vector {b,a}; a = i_vec[1:0].
// Revision : 1.0 - initial release
// ============================================================================
module abs_diff_exact
    import abs_diff_chk_pkg::*;
(
    input  logic [C_VEC_W-1:0] i_vec,
    output logic [C_OP_W-1:0]  o_exact
);

    logic [C_OP_W-1:0] w_a;
    logic [C_OP_W-1:0] w_b;

    assign w_a     = i_vec[C_OP_W-1:0];
    assign w_b     = i_vec[C_VEC_W-1:C_OP_W];
    assign o_exact = abs_diff2(w_a, w_b);

endmodule
`default_nettype wire

// File: rtl/abs_diff_et_checker.sv
`default_nettype none
// ============================================================================
// Module   : abs_diff_et_checker
// Brief    : Exhaustive 16-vector scan of a 2-bit approximate |a-b| unit,
//            tracking worst-case error, its first vector and threshold hits.
// Revision : 1.0 - initial release
// ============================================================================
module abs_diff_et_checker
    import abs_diff_chk_pkg::*;
#(
    parameter int ET     = 1,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [C_VEC_W-1:0] stim,
    input  logic [C_OP_W-1:0]  approx_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [C_OP_W-1:0]  max_err,
    output logic [C_CNT_W-1:0] viol_cnt,
    output logic [C_VEC_W-1:0] wce_vec
);

    localparam logic [3:0] C_WAIT_LAST = 4'(SETTLE - 1);

    state_t             state_q,    state_d;
    logic [C_VEC_W-1:0] vec_q,      vec_d;
    logic [3:0]         wait_q,     wait_d;
    logic [C_OP_W-1:0]  max_err_q,  max_err_d;
    logic [C_CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic [C_VEC_W-1:0] wce_vec_q,  wce_vec_d;

    logic [C_OP_W-1:0]  w_exact;
    logic [C_OP_W-1:0]  w_err;

    abs_diff_exact u_exact (
        .i_vec   (vec_q),
        .o_exact (w_exact)
    );

    assign w_err = abs_diff2(approx_out, w_exact);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        wait_d     = wait_q;
        max_err_d  = max_err_q;
        viol_cnt_d = viol_cnt_q;
        wce_vec_d  = wce_vec_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    vec_d      = '0;
                    wait_d     = '0;
                    max_err_d  = '0;
                    viol_cnt_d = '0;
                    wce_vec_d  = '0;
                end
            end
            ST_DRIVE: begin
                if (wait_q == C_WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                // Strict compare keeps the first vector that hit the maximum.
                if (w_err > max_err_q) begin
                    max_err_d = w_err;
                    wce_vec_d = vec_q;
                end
                if (int'(w_err) > ET) begin
                    viol_cnt_d = viol_cnt_q + 5'd1;
                end
                if (vec_q == 4'hF) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 4'd1;
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            wait_q     <= '0;
            max_err_q  <= '0;
            viol_cnt_q <= '0;
            wce_vec_q  <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            wait_q     <= wait_d;
            max_err_q  <= max_err_d;
            viol_cnt_q <= viol_cnt_d;
            wce_vec_q  <= wce_vec_d;
        end
    end

    assign stim     = (state_q == ST_IDLE) ? '0 : vec_q;
    assign busy     = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done     = (state_q == ST_DONE);
    assign pass     = done && (viol_cnt_q == '0);
    assign max_err  = max_err_q;
    assign viol_cnt = viol_cnt_q;
    assign wce_vec  = wce_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_abs_diff_et_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_abs_diff_et_checker
// Brief    : Directed self-checking bench: default, ET=0 and SETTLE=3 checkers
//            against exact, stuck-at-0 and exact+1 behavioural DUT models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_abs_diff_et_checker;

    logic clk = 1'b0;
    logic rst_n;
    int   mode;                     // 0 exact, 1 stuck at 0, 2 exact+1 saturating
    int   n_checks = 0;
    int   n_err    = 0;

    logic       start_def, start_et0, start_s3;
    logic [3:0] stim_def,  stim_et0,  stim_s3;
    logic [1:0] appr_def,  appr_et0,  appr_s3;
    logic       busy_def,  busy_et0,  busy_s3;
    logic       done_def,  done_et0,  done_s3;
    logic       pass_def,  pass_et0,  pass_s3;
    logic [1:0] maxe_def,  maxe_et0,  maxe_s3;
    logic [4:0] viol_def,  viol_et0,  viol_s3;
    logic [3:0] wce_def,   wce_et0,   wce_s3;

    always #5 clk = ~clk;

    function automatic logic [1:0] model(input int m, input logic [3:0] v);
        logic [1:0] a, b, ex;
        a  = v[1:0];
        b  = v[3:2];
        ex = (a >= b) ? a - b : b - a;
        if (m == 1) return 2'd0;
        if (m == 2) return (ex == 2'd3) ? 2'd3 : ex + 2'd1;
        return ex;
    endfunction

    assign appr_def = model(mode, stim_def);
    assign appr_et0 = model(mode, stim_et0);
    assign appr_s3  = model(mode, stim_s3);

    abs_diff_et_checker u_def (
        .clk(clk), .rst_n(rst_n), .start(start_def), .stim(stim_def),
        .approx_out(appr_def), .busy(busy_def), .done(done_def), .pass(pass_def),
        .max_err(maxe_def), .viol_cnt(viol_def), .wce_vec(wce_def)
    );

    abs_diff_et_checker #(.ET(0)) u_et0 (
        .clk(clk), .rst_n(rst_n), .start(start_et0), .stim(stim_et0),
        .approx_out(appr_et0), .busy(busy_et0), .done(done_et0), .pass(pass_et0),
        .max_err(maxe_et0), .viol_cnt(viol_et0), .wce_vec(wce_et0)
    );

    abs_diff_et_checker #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_s3), .stim(stim_s3),
        .approx_out(appr_s3), .busy(busy_s3), .done(done_s3), .pass(pass_s3),
        .max_err(maxe_s3), .viol_cnt(viol_s3), .wce_vec(wce_s3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic done_of(input int which);
        case (which)
            1:       return done_et0;
            2:       return done_s3;
            default: return done_def;
        endcase
    endfunction

    // Drives start for exactly one rising edge; returns #1 after that edge.
    task automatic pulse_start(input int which);
        @(negedge clk);
        case (which)
            1:       start_et0 = 1'b1;
            2:       start_s3  = 1'b1;
            default: start_def = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start_def = 1'b0;
        start_et0 = 1'b0;
        start_s3  = 1'b0;
    endtask

    task automatic wait_done(input int which, input int lat0, output int lat);
        lat = lat0;
        while (!done_of(which) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bad;
        rst_n     = 1'b0;
        start_def = 1'b0;
        start_et0 = 1'b0;
        start_s3  = 1'b0;
        mode      = 0;
        #3;
        chk("rst_stim", 32'(stim_def), 0);
        chk("rst_busy", 32'(busy_def), 0);
        chk("rst_done", 32'(done_def), 0);
        chk("rst_pass", 32'(pass_def), 0);
        chk("rst_max",  32'(maxe_def), 0);
        chk("rst_viol", 32'(viol_def), 0);
        chk("rst_wce",  32'(wce_def),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold_busy", 32'(busy_def), 0);
        chk("idle_hold_done", 32'(done_def), 0);

        // Exact DUT
        pulse_start(0);
        chk("exact_busy", 32'(busy_def), 1);
        wait_done(0, 0, lat);
        chk("exact_latency", 32'(lat), 32);
        chk("exact_pass", 32'(pass_def), 1);
        chk("exact_max",  32'(maxe_def), 0);
        chk("exact_viol", 32'(viol_def), 0);
        chk("exact_wce",  32'(wce_def),  0);
        chk("exact_stim_done", 32'(stim_def), 15);
        chk("exact_busy_done", 32'(busy_def), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("done_held", 32'(done_def), 1);
        chk("pass_held", 32'(pass_def), 1);

        // Stuck-at-0 DUT, restarted from DONE
        mode = 1;
        pulse_start(0);
        chk("restart_done_fall", 32'(done_def), 0);
        chk("restart_max_clear", 32'(maxe_def), 0);
        wait_done(0, 0, lat);
        chk("stuck_latency", 32'(lat), 32);
        chk("stuck_max",  32'(maxe_def), 3);
        chk("stuck_wce",  32'(wce_def),  3);
        chk("stuck_viol", 32'(viol_def), 6);
        chk("stuck_pass", 32'(pass_def), 0);

        // exact+1 saturating, ET=1 and ET=0
        mode = 2;
        pulse_start(0);
        wait_done(0, 0, lat);
        chk("plus1_max",  32'(maxe_def), 1);
        chk("plus1_viol", 32'(viol_def), 0);
        chk("plus1_pass", 32'(pass_def), 1);
        chk("plus1_wce",  32'(wce_def),  0);
        pulse_start(1);
        wait_done(1, 0, lat);
        chk("et0_latency", 32'(lat), 32);
        chk("et0_max",  32'(maxe_et0), 1);
        chk("et0_viol", 32'(viol_et0), 14);
        chk("et0_pass", 32'(pass_et0), 0);

        // start re-pulsed mid-scan must be ignored
        mode = 1;
        pulse_start(0);
        lat = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start_def = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start_def = 1'b0;
        wait_done(0, lat, lat);
        chk("repulse_latency", 32'(lat), 32);
        chk("repulse_max",  32'(maxe_def), 3);
        chk("repulse_viol", 32'(viol_def), 6);
        chk("repulse_wce",  32'(wce_def),  3);

        // Asynchronous reset mid-scan, then a clean rescan
        pulse_start(0);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stim", 32'(stim_def), 0);
        chk("arst_busy", 32'(busy_def), 0);
        chk("arst_done", 32'(done_def), 0);
        chk("arst_pass", 32'(pass_def), 0);
        chk("arst_max",  32'(maxe_def), 0);
        chk("arst_viol", 32'(viol_def), 0);
        chk("arst_wce",  32'(wce_def),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_idle_busy", 32'(busy_def), 0);
        pulse_start(0);
        wait_done(0, 0, lat);
        chk("arst_rescan_latency", 32'(lat), 32);
        chk("arst_rescan_max",  32'(maxe_def), 3);
        chk("arst_rescan_viol", 32'(viol_def), 6);
        chk("arst_rescan_wce",  32'(wce_def),  3);

        // SETTLE=3: each vector held 4 cycles
        mode = 0;
        pulse_start(2);
        lat = 0;
        bad = 0;
        while (!done_s3 && lat < 200) begin
            if (stim_s3 !== 4'(lat / 4)) bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("s3_latency", 32'(lat), 64);
        chk("s3_stim_hold_errs", 32'(bad), 0);
        chk("s3_pass", 32'(pass_s3), 1);
        chk("s3_max",  32'(maxe_s3), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
